// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequential 16-bit ALU controller.
// Single-cycle logic/arith ops finish one cycle after acceptance. Signed
// multiply (radix-2 Booth) and unsigned divide (restoring) take 16
// iterations. The result is held in DONE until the consumer accepts it.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
);

  localparam logic [3:0] OP_INV  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SHR1 = 4'b0110;
  localparam logic [3:0] OP_SHL1 = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [3:0]  op_r;
  logic [15:0] a_r;
  // acc_r is the Booth A register (17 bits so subtracting -32768 cannot
  // overflow) and doubles as the divider partial remainder.
  logic [16:0] acc_r;
  // q_r is the Booth multiplier/product-low register, or the divider
  // dividend/quotient register.
  logic [15:0] q_r;
  logic        qm1_r;
  // m_r holds the multiplicand (mul) or the divisor (div).
  logic [15:0] m_r;

  logic        cmd_ready_r;
  logic        res_valid_r;
  logic [31:0] res_data_r;
  logic        res_err_r;
  logic        busy_r;

  logic [31:0] single_data_s;
  logic        single_err_s;
  logic [16:0] add_s;
  logic [16:0] sub_s;

  logic [16:0] booth_sum_s;
  logic [16:0] booth_acc_s;
  logic [15:0] booth_q_s;
  logic        booth_qm1_s;

  logic [16:0] div_shift_s;
  logic [17:0] div_diff_s;
  logic [16:0] div_rem_s;
  logic [15:0] div_q_s;

  assign cmd_ready = cmd_ready_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_err   = res_err_r;
  assign busy      = busy_r;

  // Result of the one-cycle opcodes, computed straight from the command inputs.
  always_comb begin
    single_data_s = 32'h0000_0000;
    single_err_s  = 1'b0;
    add_s         = {1'b0, cmd_a} + {1'b0, cmd_b};
    sub_s         = {1'b0, cmd_a} - {1'b0, cmd_b};
    case (cmd_op)
      OP_INV:  single_data_s = {16'h0000, ~cmd_a};
      OP_OR:   single_data_s = {16'h0000, cmd_a | cmd_b};
      OP_AND:  single_data_s = {16'h0000, cmd_a & cmd_b};
      OP_XOR:  single_data_s = {16'h0000, cmd_a ^ cmd_b};
      OP_ADD:  single_data_s = {15'h0000, add_s};
      OP_SUB:  single_data_s = {15'h0000, sub_s};
      OP_SHR1: single_data_s = {16'h0000, 1'b0, cmd_a[15:1]};
      OP_SHL1: single_data_s = {16'h0000, cmd_a[14:0], 1'b0};
      OP_MUL:  single_data_s = 32'h0000_0000;
      OP_DIV:  single_data_s = 32'h0000_0000;
      default: begin
        single_data_s = 32'h0000_0000;
        single_err_s  = 1'b1;
      end
    endcase
  end

  // One Booth step: add/subtract the multiplicand, then arithmetic shift {A,Q,q-1}.
  always_comb begin
    booth_sum_s = acc_r;
    case ({q_r[0], qm1_r})
      2'b01:   booth_sum_s = acc_r + {m_r[15], m_r};
      2'b10:   booth_sum_s = acc_r - {m_r[15], m_r};
      default: booth_sum_s = acc_r;
    endcase
    booth_acc_s = {booth_sum_s[16], booth_sum_s[16:1]};
    booth_q_s   = {booth_sum_s[0], q_r[15:1]};
    booth_qm1_s = q_r[0];
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    div_shift_s = {acc_r[15:0], q_r[15]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, m_r};
    if (div_diff_s[17] == 1'b0) begin
      div_rem_s = div_diff_s[16:0];
      div_q_s   = {q_r[14:0], 1'b1};
    end else begin
      div_rem_s = div_shift_s;
      div_q_s   = {q_r[14:0], 1'b0};
    end
  end

  // Control FSM with registered handshake outputs and iterative datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      op_r        <= 4'd0;
      a_r         <= 16'h0000;
      acc_r       <= 17'h0_0000;
      q_r         <= 16'h0000;
      qm1_r       <= 1'b0;
      m_r         <= 16'h0000;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= 32'h0000_0000;
      res_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            op_r        <= cmd_op;
            a_r         <= cmd_a;
            cnt_r       <= 5'd0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if ((cmd_op == OP_MUL) || (cmd_op == OP_DIV)) begin
              state_r <= ST_EXEC;
              acc_r   <= 17'h0_0000;
              qm1_r   <= 1'b0;
              if (cmd_op == OP_MUL) begin
                q_r <= cmd_b;
                m_r <= cmd_a;
              end else begin
                q_r <= cmd_a;
                m_r <= cmd_b;
              end
            end else begin
              state_r     <= ST_DONE;
              res_valid_r <= 1'b1;
              res_data_r  <= single_data_s;
              res_err_r   <= single_err_s;
            end
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r + 5'd1;
          if (op_r == OP_MUL) begin
            acc_r <= booth_acc_s;
            q_r   <= booth_q_s;
            qm1_r <= booth_qm1_s;
          end else begin
            acc_r <= div_rem_s;
            q_r   <= div_q_s;
            qm1_r <= 1'b0;
          end
          // Sixteenth step: publish the result from this step's combinational output.
          if (cnt_r == 5'd15) begin
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
            if (op_r == OP_MUL) begin
              res_data_r <= {booth_acc_s[15:0], booth_q_s};
              res_err_r  <= 1'b0;
            end else if (m_r == 16'h0000) begin
              res_data_r <= {a_r, 16'hFFFF};
              res_err_r  <= 1'b1;
            end else begin
              res_data_r <= {div_rem_s[15:0], div_q_s};
              res_err_r  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a transaction-level reference model
// (plain arithmetic plus a countdown) is compared with the DUT every cycle,
// with directed cases pinned to hand-computed literals and a random soak.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: phase 0 = idle, 1 = computing, 2 = result held.
  int          m_phase = 0;
  int          m_wait  = 0;
  logic [31:0] m_data  = 32'h0;
  logic        m_err   = 1'b0;
  logic [32:0] m_pend  = 33'h0;
  bit          m_known = 1'b0;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected {err, data} of one command, from the opcode definitions.
  function automatic logic [32:0] ref_result(input logic [3:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    int          sa;
    int          sb;
    int          prod;
    logic [15:0] d16;
    logic [15:0] qq;
    logic [15:0] rr;
    case (op)
      4'd0: return {1'b0, 16'h0000, ~a};
      4'd1: return {1'b0, 16'h0000, a | b};
      4'd2: return {1'b0, 16'h0000, a & b};
      4'd3: return {1'b0, 16'h0000, a ^ b};
      4'd4: return {1'b0, 32'(a) + 32'(b)};
      4'd5: begin
        d16 = a - b;
        return {1'b0, 15'h0000, (a < b) ? 1'b1 : 1'b0, d16};
      end
      4'd6: return {1'b0, 16'h0000, a >> 1};
      4'd7: return {1'b0, 16'h0000, a << 1};
      4'd8: begin
        sa   = $signed(a);
        sb   = $signed(b);
        prod = sa * sb;
        return {1'b0, prod};
      end
      4'd9: begin
        if (b == 16'h0000) return {1'b1, a, 16'hFFFF};
        qq = a / b;
        rr = a % b;
        return {1'b0, rr, qq};
      end
      default: return {1'b1, 32'h0000_0000};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare every DUT output at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1;
      m_phase = 0;
      m_data  = 32'h0;
      m_err   = 1'b0;
    end else if (m_phase == 2) begin
      if (res_ready) m_phase = 0;
    end else if (m_phase == 1) begin
      m_wait--;
      if (m_wait == 0) begin
        m_phase = 2;
        m_data  = m_pend[31:0];
        m_err   = m_pend[32];
      end
    end else if (cmd_valid) begin
      m_pend = ref_result(cmd_op, cmd_a, cmd_b);
      if ((cmd_op == 4'd8) || (cmd_op == 4'd9)) begin
        m_phase = 1;
        m_wait  = 16;
      end else begin
        m_phase = 2;
        m_data  = m_pend[31:0];
        m_err   = m_pend[32];
      end
    end
    @(negedge clk);
    if (m_known) begin
      chk("model_res_valid", res_valid, (m_phase == 2));
      chk("model_busy",      busy,      (m_phase != 0));
      chk("model_cmd_ready", cmd_ready, (m_phase == 0));
      chk("model_res_data",  res_data,  m_data);
      chk("model_res_err",   res_err,   m_err);
    end
  endtask

  // Issue one command from idle, keep garbage on the command bus while busy,
  // hold the result for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    res_ready = 1'b0;
    cycle();
    cmd_op = ~op;
    cmd_a  = ~a;
    cmd_b  = b ^ 16'h5A5A;
    lat = 1;
    while ((res_valid !== 1'b1) && (lat < 40)) begin
      cycle();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("res_data", res_data, exp_data);
    chk("res_err", res_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      cycle();
      chk("hold_res_data", res_data, exp_data);
      chk("hold_cmd_ready", cmd_ready, 32'h0);
    end
    res_ready = 1'b1;
    cycle();
    chk("ready_after_handshake", cmd_ready, 32'h1);
    chk("valid_after_handshake", res_valid, 32'h0);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 16'h0000;
    cmd_b     = 16'h0000;
    res_ready = 1'b0;

    // Reset state.
    cycle();
    cycle();
    chk("rst_res_valid", res_valid, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_err", res_err, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 32'h1);
    rst = 1'b0;
    cycle();

    // Directed cases with hand-computed results.
    run_op(4'd9,  16'h0009, 16'h0003, 32'h0000_0003, 1'b0, 17, 0);
    run_op(4'd8,  16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0, 17, 0);
    run_op(4'd8,  16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17, 0);
    run_op(4'd9,  16'h0007, 16'h0000, 32'h0007_FFFF, 1'b1, 17, 0);
    run_op(4'd12, 16'h1234, 16'h5678, 32'h0000_0000, 1'b1, 1, 0);
    run_op(4'd4,  16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1, 5);
    run_op(4'd5,  16'h0001, 16'h0002, 32'h0001_FFFF, 1'b0, 1, 0);
    run_op(4'd9,  16'hFFFF, 16'h0007, 32'h0001_2492, 1'b0, 17, 0);
    run_op(4'd7,  16'h8001, 16'h0000, 32'h0000_0002, 1'b0, 1, 0);

    // Reset on the 8th EXEC cycle of a multiply aborts it.
    cmd_valid = 1'b1;
    cmd_op    = 4'd8;
    cmd_a     = 16'h1234;
    cmd_b     = 16'h0042;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b1;
    cycle();
    chk("abort_res_valid", res_valid, 32'h0);
    chk("abort_busy", busy, 32'h0);
    chk("abort_cmd_ready", cmd_ready, 32'h1);
    rst = 1'b0;
    run_op(4'd9, 16'h0009, 16'h0003, 32'h0000_0003, 1'b0, 17, 0);

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) cmd_op = 4'd8 + 4'($urandom_range(0, 1));
      else                           cmd_op = 4'($urandom_range(0, 15));
      cmd_a     = pick16();
      cmd_b     = pick16();
      res_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 No parameters; data width SHALL be fixed at 16 bits for operands and 32 bits for results.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  requester presents a command.
REQ-005 cmd_ready  output  1  controller can accept a command this cycle.
REQ-006 cmd_op  input  4  opcode: 0000 inv, 0001 or, 0010 and, 0011 xor, 0100 add, 0101 sub, 0110 shr1, 0111 shl1, 1000 mul (signed), 1001 div (unsigned), 1010-1111 illegal.
REQ-007 cmd_a  input  16  operand A (dividend, multiplicand, shift source).
REQ-008 cmd_b  input  16  operand B (divisor, multiplier).
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_data  output  32  result.
REQ-012 res_err  output  1  result is an error (illegal op or divide by zero).
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; command accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-016 On acceptance, cmd_op, cmd_a, cmd_b SHALL be captured; later input changes SHALL not affect the operation.
REQ-017 Single-cycle ops (0000-0111, illegal): IDLE -> DONE on acceptance; res_valid SHALL assert on the cycle after the accepting edge (latency 1).
REQ-018 mul/div: IDLE -> EXEC on acceptance; a 5-bit iteration counter SHALL run 16 steps, one per cycle; EXEC -> DONE after step 16; res_valid SHALL assert 17 cycles after the accepting edge.
REQ-019 mul SHALL use radix-2 Booth recoding with arithmetic right shift of {A,Q,q-1}; res_data = full signed 32-bit product of cmd_a and cmd_b.
REQ-020 div SHALL use restoring shift-subtract; res_data = {remainder[15:0], quotient[15:0]}, unsigned, 17-bit partial remainder so dividends >= 16'h8000 are correct.
REQ-021 div with cmd_b=0 SHALL still take 17 cycles and return {cmd_a, 16'hFFFF} with res_err=1.
REQ-022 Logic ops and shifts: res_data = {16'h0000, 16-bit result}; shr1/shl1 are logical 1-bit shifts filling 0.
REQ-023 add: res_data = {15'b0, carry_out, A+B mod 2^16}.
REQ-024 sub: res_data = {15'b0, borrow, A-B mod 2^16}, borrow=1 iff A<B unsigned.
REQ-025 Illegal opcode: res_data=0, res_err=1, latency 1.
REQ-026 res_err SHALL be 0 for every legal, non-faulting operation.
REQ-027 In DONE, res_valid=1 and res_data/res_err SHALL hold stable until res_ready=1; DONE -> IDLE on that cycle.
REQ-028 res_valid SHALL be 0 in IDLE and EXEC; res_data SHALL retain its last value outside DONE.
REQ-029 No new command SHALL be accepted in the cycle res_ready completes the handshake; earliest next acceptance is the following cycle.
REQ-030 cmd_valid while busy SHALL be ignored (no queuing, no state change).

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, counter=0, res_valid=0, res_data=0, res_err=0, busy=0, cmd_ready=1 on the next cycle.
REQ-032 rst SHALL take priority over any handshake; reset during EXEC or DONE SHALL abort the operation with no result emitted.

Verification
REQ-033 div A=16'h0009, B=16'h0003, res_ready=1 -> res_valid exactly 17 cycles after accept, res_data=32'h0000_0003, res_err=0.
REQ-034 mul A=16'hFFFD (-3), B=16'h0005 -> res_data=32'hFFFF_FFF1 at accept+17; also 16'h8000*16'h8000 -> 32'h4000_0000.
REQ-035 div A=16'h0007, B=0 -> res_data=32'h0007_FFFF, res_err=1; illegal op 4'b1100 -> res_data=0, res_err=1 at accept+1.
REQ-036 add A=16'hFFFF, B=16'h0001 -> 32'h0001_0000; sub A=16'h0001, B=16'h0002 -> 32'h0001_FFFF; res_ready held low 5 cycles -> res_data stable, cmd_ready=0, cmd_valid ignored throughout.
REQ-037 rst=1 at the 8th EXEC cycle of a mul -> next cycle res_valid=0, busy=0, cmd_ready=1; following div 9/3 completes correctly in 17 cycles.
